serial_stream_gate: RTL

SERIAL_STREAM_GATE -- requirements
Module: serial_stream_gate

---
 rtl/serial_stream_gate.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_stream_gate.sv
// Command-framed stream gate: accepts {swap,len}, forwards len words through a
// small FIFO and optionally reverses byte order on the way out.

module ssg_byte_lane #(
  parameter int W    = 64,
  parameter int LANE = 0
) (
  input  logic [W-1:0] head,
  input  logic         swap,
  output logic [7:0]   lane
);
  localparam int NB = W / 8;
  assign lane = swap ? head[(NB-1-LANE)*8 +: 8] : head[LANE*8 +: 8];
endmodule

module serial_stream_gate #(
  parameter int W        = 64,
  parameter int DEPTH    = 4,
  parameter int LEN_BITS = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LEN_BITS:0]        cmd,
  input  logic                     cmd_hasAny,
  output logic                     cmd_consume,
  input  logic [W-1:0]             in,
  input  logic                     in_isReady,
  output logic                     in_canReceive,
  output logic [W-1:0]             out,
  output logic                     out_isReady,
  input  logic                     out_canReceive,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = W / 8;

  typedef struct packed {
    logic                swap;
    logic [LEN_BITS-1:0] len;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  cmd_t                  cmd_req;
  state_t                state, state_nxt;
  logic [LEN_BITS-1:0]   remaining;
  logic                  swap_q;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DEPTH-1:0][W-1:0] mem;
  logic [W-1:0]          head;
  logic [NB-1:0][7:0]    out_lanes;
  logic                  accept, push, pop;
  logic [AW:0]           count_nxt;

  assign cmd_req = cmd;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Handshake outputs come from registered state only; reset forces them low.
  always_comb begin
    state_nxt     = state;
    cmd_consume   = 1'b0;
    in_canReceive = 1'b0;
    out_isReady   = 1'b0;
    if (rst) begin
      cmd_consume   = cmd_hasAny && (state == IDLE);
      in_canReceive = (state == XFER) && (remaining != '0) && (count < (AW+1)'(DEPTH));
      out_isReady   = (count != '0);
    end
    accept    = cmd_consume && (cmd_req.len != '0);
    push      = in_isReady && in_canReceive;
    pop       = out_isReady && out_canReceive;
    count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    case (state)
      IDLE:    if (accept) state_nxt = XFER;
      XFER:    if (push && (remaining == LEN_BITS'(1))) state_nxt = DRAIN;
      DRAIN:   if (count_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      remaining <= '0;
      swap_q    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (accept) begin
        remaining <= cmd_req.len;
        swap_q    <= cmd_req.swap;
      end else if (push) begin
        remaining <= remaining - LEN_BITS'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Storage needs no reset: nothing is visible on out until count says so.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in;
  end

  assign head = mem[rd_ptr];

  for (genvar i = 0; i < NB; i++) begin : g_lane
    ssg_byte_lane #(.W(W), .LANE(i)) u_lane (
      .head (head),
      .swap (swap_q),
      .lane (out_lanes[i])
    );
  end

  assign out  = out_isReady ? out_lanes : '0;
  assign busy = (state != IDLE);

endmodule
